// File: rtl/pipe_ex_exmem.sv
// Execute stage: operand forwarding, ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register feeding the memory stage.
module pipe_ex_exmem #(
   parameter int MUL_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   input  logic [31:0] Imm32,
   input  logic [4:0]  Shamt,
   input  logic [4:0]  Rs,
   input  logic [4:0]  Rt,
   input  logic [3:0]  ALUOp,
   input  logic        ALUSrc,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic        RegWr,
   input  logic        MemToReg,
   input  logic [4:0]  WriteReg,
   input  logic        flush,
   input  logic [70:0] MEMWB,
   output logic [72:0] EXMEM,
   output logic        stall
);

   localparam int CNT_W = $clog2(MUL_STEPS + 1);
   localparam logic [3:0] OP_MUL = 4'b1011;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [72:0]       r_exmem;
   logic [72:0]       w_exmem_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_mcand;
   logic [31:0]       r_mplier;
   logic [31:0]       r_prod;
   logic [8:0]        r_ctl;
   logic [31:0]       r_wdata;
   logic [31:0]       w_fwd_rs;
   logic [31:0]       w_fwd_rt;
   logic [31:0]       w_a;
   logic [31:0]       w_b;
   logic [31:0]       w_result;
   logic              w_stall;
   logic              w_start;

   // A load sitting in EX/MEM has no data yet, so it is never a forwarding source
   function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf,
                                       input logic [72:0] exmem, input logic [70:0] memwb);
      logic [31:0] val;
      if (exmem[70] && (exmem[68:64] != 5'd0) && (exmem[68:64] == src) && !exmem[71]) begin
         val = exmem[31:0];
      end else if (memwb[70] && (memwb[68:64] != 5'd0) && (memwb[68:64] == src)) begin
         val = memwb[69] ? memwb[63:32] : memwb[31:0];
      end else begin
         val = rf;
      end
      return val;
   endfunction

   assign w_fwd_rs = fwd(Rs, RsData, r_exmem, MEMWB);
   assign w_fwd_rt = fwd(Rt, RtData, r_exmem, MEMWB);
   assign w_a      = w_fwd_rs;
   assign w_b      = ALUSrc ? Imm32 : w_fwd_rt;

   // Single-cycle ALU; MUL is handled by the sequential multiplier instead
   always_comb begin
      w_result = 32'd0;
      case (ALUOp)
         4'b0000: w_result = w_a + w_b;
         4'b0001: w_result = w_a - w_b;
         4'b0010: w_result = w_a & w_b;
         4'b0011: w_result = w_a | w_b;
         4'b0100: w_result = w_a ^ w_b;
         4'b0101: w_result = ~(w_a | w_b);
         4'b0110: w_result = w_b << Shamt;
         4'b0111: w_result = w_b >> Shamt;
         4'b1000: w_result = $unsigned($signed(w_b) >>> Shamt);
         4'b1001: w_result = {31'd0, ($signed(w_a) < $signed(w_b))};
         4'b1010: w_result = {31'd0, (w_a < w_b)};
         4'b1100: w_result = {w_b[15:0], 16'd0};
         default: w_result = 32'd0;
      endcase
   end

   // Next state, stall and the value loaded into EX/MEM (bubble by default)
   always_comb begin
      w_state_nxt = r_state;
      w_exmem_nxt = 73'd0;
      w_stall     = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else if (ALUOp == OP_MUL) begin
               w_stall     = 1'b1;
               w_start     = 1'b1;
               w_state_nxt = S_BUSY;
            end else begin
               w_exmem_nxt = {MemWr, MemRd, RegWr, MemToReg, WriteReg, w_fwd_rt, w_result};
            end
         end
         S_BUSY: begin
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_cnt == LAST_STEP) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_BUSY;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            if (flush) begin
               w_exmem_nxt = 73'd0;
            end else begin
               w_exmem_nxt = {r_ctl, r_wdata, r_prod};
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, pipeline register and multiplier datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_exmem  <= 73'd0;
         r_cnt    <= '0;
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
         r_prod   <= 32'd0;
         r_ctl    <= 9'd0;
         r_wdata  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_exmem <= w_exmem_nxt;
         if (w_start) begin
            r_mcand  <= w_a;
            r_mplier <= w_b;
            r_prod   <= 32'd0;
            r_cnt    <= '0;
            r_ctl    <= {MemWr, MemRd, RegWr, MemToReg, WriteReg};
            r_wdata  <= w_fwd_rt;
         end else if (r_state == S_BUSY) begin
            if (r_mplier[0]) begin
               r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign EXMEM = r_exmem;
   // Gated by reset so an in-flight MUL on the inputs cannot stall during reset
   assign stall = w_stall & reset;

endmodule

// File: tb/tb_pipe_ex_exmem.sv
// Directed bench for pipe_ex_exmem with an EXMEM scoreboard queue.
module tb_pipe_ex_exmem;
   logic        clk;
   logic        reset;
   logic [31:0] RsData, RtData, Imm32;
   logic [4:0]  Shamt, Rs, Rt, WriteReg;
   logic [3:0]  ALUOp;
   logic        ALUSrc, MemRd, MemWr, RegWr, MemToReg, flush;
   logic [70:0] MEMWB;
   logic [72:0] EXMEM;
   logic        stall;

   int checks   = 0;
   int failures = 0;
   logic [72:0] sb_q[$];

   pipe_ex_exmem #(.MUL_STEPS(32)) dut (
      .clk(clk), .reset(reset), .RsData(RsData), .RtData(RtData), .Imm32(Imm32),
      .Shamt(Shamt), .Rs(Rs), .Rt(Rt), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
      .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr), .MemToReg(MemToReg),
      .WriteReg(WriteReg), .flush(flush), .MEMWB(MEMWB), .EXMEM(EXMEM), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [72:0] mk(input logic mw, input logic mr, input logic rw,
                                      input logic mtr, input logic [4:0] wr,
                                      input logic [31:0] wd, input logic [31:0] res);
      return {mw, mr, rw, mtr, wr, wd, res};
   endfunction

   task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      logic [72:0] exp;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         exp = sb_q.pop_front();
         chk(tag, EXMEM, exp);
      end
   endtask

   task automatic set_nop();
      RsData = 32'd0; RtData = 32'd0; Imm32 = 32'd0; Shamt = 5'd0;
      Rs = 5'd0; Rt = 5'd0; ALUOp = 4'd0; ALUSrc = 1'b0; MemRd = 1'b0;
      MemWr = 1'b0; RegWr = 1'b0; MemToReg = 1'b0; WriteReg = 5'd0; flush = 1'b0;
   endtask

   task automatic op(input logic [3:0] alu, input logic [4:0] rsn, input logic [31:0] rsd,
                     input logic [4:0] rtn, input logic [31:0] rtd, input logic [31:0] imm,
                     input logic src, input logic rw, input logic [4:0] wr);
      set_nop();
      ALUOp = alu; Rs = rsn; RsData = rsd; Rt = rtn; RtData = rtd;
      Imm32 = imm; ALUSrc = src; RegWr = rw; WriteReg = wr;
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wr, input logic [31:0] prod);
      op(4'b1011, 5'd0, a, 5'd0, b, 32'd0, 1'b0, 1'b1, wr);
      for (int k = 0; k < 33; k++) begin
         #1;
         chk("mul_stall_high", {72'd0, stall}, 73'd1);
         sb_q.push_back(73'd0);
         tick("mul_bubble");
      end
      #1;
      chk("mul_done_stall_low", {72'd0, stall}, 73'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, wr, b, prod));
      tick("mul_result");
      set_nop();
   endtask

   initial begin
      set_nop();
      MEMWB = 71'd0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("reset_exmem", EXMEM, 73'd0);
      chk("reset_stall", {72'd0, stall}, 73'd0);
      #10 reset = 1'b1;

      // ADD wrap to 0x80000000
      op(4'b0000, 5'd1, 32'h7FFF_FFFF, 5'd0, 32'd0, 32'd1, 1'b1, 1'b1, 5'd5);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'd0, 32'h8000_0000));
      tick("add_wrap");

      // EX/MEM forwarding: r3 = 1 + 2, then r4 = r3 - 1 with stale RF value
      op(4'b0000, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 1'b1, 5'd3);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'd2, 32'd3));
      tick("add_r3");
      op(4'b0001, 5'd3, 32'd99, 5'd0, 32'd0, 32'd1, 1'b1, 1'b1, 5'd4);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'd0, 32'd2));
      tick("sub_fwd_exmem");

      // load into r6; a load in EX/MEM is not forwarded
      op(4'b0000, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, 1'b1, 1'b1, 5'd6);
      MemRd = 1'b1; MemToReg = 1'b1;
      sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'd0, 32'h104));
      tick("load_r6");
      op(4'b0000, 5'd6, 32'h55, 5'd0, 32'd0, 32'd1, 1'b1, 1'b1, 5'd7);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'd0, 32'h56));
      tick("no_fwd_from_load");

      // MEMWB forwarding of ReadData (Rs and Rt), then of ALUOut
      op(4'b0000, 5'd6, 32'd77, 5'd6, 32'd0, 32'h20, 1'b1, 1'b1, 5'd8);
      MEMWB = {1'b1, 1'b1, 5'd6, 32'h10, 32'h104};
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h10, 32'h30));
      tick("fwd_memwb_readdata");
      op(4'b0000, 5'd6, 32'd77, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd14);
      MEMWB = {1'b1, 1'b0, 5'd6, 32'h10, 32'h104};
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd14, 32'd0, 32'h104));
      tick("fwd_memwb_aluout");
      MEMWB = 71'd0;

      // compare and shift operations
      op(4'b1001, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1, 32'd1));
      tick("slt_signed");
      op(4'b1010, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1, 32'd0));
      tick("sltu");
      op(4'b1000, 5'd0, 32'h8000_0000, 5'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 5'd0);
      Shamt = 5'd4;
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h8000_0000, 32'hF800_0000));
      tick("sra");
      op(4'b1100, 5'd0, 32'd0, 5'd0, 32'd9, 32'h1234, 1'b1, 1'b0, 5'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd9, 32'h1234_0000));
      tick("lui");
      op(4'b1101, 5'd0, 32'd5, 5'd0, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd3, 32'd0));
      tick("undefined_op");

      // multiplies
      do_mul(32'h0001_2345, 32'h0000_0100, 5'd9, 32'h0123_4500);
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001);

      // flush in BUSY cycle 10 aborts the multiply
      op(4'b1011, 5'd0, 32'h1234, 5'd0, 32'h10, 32'd0, 1'b0, 1'b1, 5'd10);
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("flushmul_stall_high", {72'd0, stall}, 73'd1);
         sb_q.push_back(73'd0);
         tick("flushmul_bubble");
      end
      flush = 1'b1;
      #1;
      chk("flush_stall_low", {72'd0, stall}, 73'd0);
      sb_q.push_back(73'd0);
      tick("flush_bubble");
      op(4'b0000, 5'd0, 32'd40, 5'd0, 32'd2, 32'd0, 1'b0, 1'b1, 5'd11);
      #1;
      chk("post_flush_stall", {72'd0, stall}, 73'd0);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 32'd2, 32'd42));
      tick("post_flush_add");
      set_nop();
      for (int k = 0; k < 36; k++) begin
         sb_q.push_back(73'd0);
         tick("no_aborted_product");
      end

      // asynchronous reset with a result in EX/MEM and a MUL presented
      op(4'b0000, 5'd0, 32'd5, 5'd0, 32'd6, 32'd0, 1'b0, 1'b1, 5'd12);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'd6, 32'd11));
      tick("pre_reset_add");
      op(4'b1011, 5'd0, 32'd3, 5'd0, 32'd4, 32'd0, 1'b0, 1'b1, 5'd12);
      #1;
      chk("pre_reset_stall", {72'd0, stall}, 73'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_exmem", EXMEM, 73'd0);
      chk("async_reset_stall", {72'd0, stall}, 73'd0);
      set_nop();
      #2 reset = 1'b1;
      sb_q.push_back(73'd0);
      tick("after_reset_nop");
      op(4'b0010, 5'd0, 32'hF0F0, 5'd0, 32'h0FF0, 32'd0, 1'b0, 1'b1, 5'd2);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0FF0, 32'h00F0));
      tick("after_reset_and");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
